// File: rtl/super_counter_pkg.sv
// rtl/super_counter_pkg.sv - shared channel state type and counter width helpers
package super_counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    REPEATING
  } ch_state_t;

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - synchroniser, debouncer, press/repeat FSM for one button
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   btn          : raw asynchronous button (X/Z reads as 0)
//   debounced    : registered debounced level
//   event_pulse  : registered one-cycle pulse per press or repeat event
module button_channel
  import super_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 0,
  parameter int REPEAT_CYCLES   = 1200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic debounced,
  output logic event_pulse
);

  localparam int DB_W    = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TMR_W   = cnt_width(TMR_MAX);

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [DB_W-1:0]  db_cnt;
  ch_state_t        state;
  ch_state_t        state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_nxt;
  logic             ev_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      db_cnt      <= '0;
      debounced   <= 1'b0;
      state       <= IDLE;
      tmr         <= '0;
      event_pulse <= 1'b0;
    end else begin
      // Only a definite 1 counts as pressed; X/Z fall to 0.
      sync1 <= (btn === 1'b1);
      sync2 <= sync1;
      // The level must differ for DEBOUNCE_CYCLES consecutive samples;
      // any sample matching the current level restarts the count.
      if (sync2 == debounced) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        debounced <= sync2;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
      state       <= state_nxt;
      tmr         <= tmr_nxt;
      event_pulse <= ev_nxt;
    end
  end

  // The timer counts cycles since the last event; the event is registered
  // on the edge where the timer reaches its last value, so pulses land
  // exactly HOLD_CYCLES / REPEAT_CYCLES apart.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    ev_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (debounced) begin
          state_nxt = PRESSED;
          tmr_nxt   = '0;
          ev_nxt    = 1'b1;
        end
      end
      PRESSED: begin
        if (!debounced) begin
          state_nxt = IDLE;
        end else if (HOLD_CYCLES > 0) begin
          if (tmr == HOLD_LAST) begin
            state_nxt = REPEATING;
            tmr_nxt   = '0;
            ev_nxt    = 1'b1;
          end else begin
            tmr_nxt = tmr + 1'b1;
          end
        end
      end
      REPEATING: begin
        if (!debounced) begin
          state_nxt = IDLE;
        end else if (tmr == REP_LAST) begin
          tmr_nxt = '0;
          ev_nxt  = 1'b1;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/multi_button_counter.sv
// rtl/multi_button_counter.sv - N-channel debounced up/down button counter with LED pulses
// Ports:
//   clk_12m, rst_n : clock, synchronous active-low reset
//   btn            : raw buttons, active-high
//   count_down     : per-channel direction (0 = +1, 1 = -1)
//   clear          : per-channel synchronous counter/limit clear
//   btn_count      : flattened counters, channel i at [i*COUNT_WIDTH +: COUNT_WIDTH]
//   btn_debounced  : debounced levels
//   count_event    : one-cycle pulse per press/repeat event
//   limit_hit      : sticky wrap/clamp flag per channel
//   led, any_led   : stretched event pulses and their OR
module multi_button_counter
  import super_counter_pkg::*;
#(
  parameter int NUM_BTNS         = 4,
  parameter int COUNT_WIDTH      = 16,
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int HOLD_CYCLES      = 0,
  parameter int REPEAT_CYCLES    = 1200,
  parameter int LED_PULSE_CYCLES = 100,
  parameter int SATURATE         = 0
) (
  input  logic                            clk_12m,
  input  logic                            rst_n,
  input  logic [NUM_BTNS-1:0]             btn,
  input  logic [NUM_BTNS-1:0]             count_down,
  input  logic [NUM_BTNS-1:0]             clear,
  output logic [NUM_BTNS*COUNT_WIDTH-1:0] btn_count,
  output logic [NUM_BTNS-1:0]             btn_debounced,
  output logic [NUM_BTNS-1:0]             count_event,
  output logic [NUM_BTNS-1:0]             limit_hit,
  output logic [NUM_BTNS-1:0]             led,
  output logic                            any_led
);

  localparam int                     LED_W    = cnt_width(LED_PULSE_CYCLES);
  localparam logic [LED_W-1:0]       LED_LOAD = LED_W'(LED_PULSE_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    logic [COUNT_WIDTH-1:0] cnt;
    logic                   lim;
    logic [LED_W-1:0]       led_cnt;
    logic                   led_q;

    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk         (clk_12m),
      .rst_n       (rst_n),
      .btn         (btn[i]),
      .debounced   (btn_debounced[i]),
      .event_pulse (count_event[i])
    );

    always_ff @(posedge clk_12m) begin
      if (!rst_n) begin
        cnt     <= '0;
        lim     <= 1'b0;
        led_cnt <= '0;
        led_q   <= 1'b0;
      end else begin
        // clear wins over a coincident event for counting purposes only.
        if (clear[i]) begin
          cnt <= '0;
          lim <= 1'b0;
        end else if (count_event[i]) begin
          if (count_down[i]) begin
            if (cnt == '0) begin
              lim <= 1'b1;
              if (SATURATE == 0) cnt <= CNT_MAX;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end else begin
            if (cnt == CNT_MAX) begin
              lim <= 1'b1;
              if (SATURATE == 0) cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        // led_q mirrors (led_cnt != 0) one register earlier so the output
        // is itself a flop and stays high exactly LED_PULSE_CYCLES cycles.
        if (count_event[i]) begin
          led_cnt <= LED_LOAD;
          led_q   <= 1'b1;
        end else if (led_cnt != '0) begin
          led_cnt <= led_cnt - 1'b1;
          led_q   <= (led_cnt != LED_W'(1));
        end else begin
          led_q <= 1'b0;
        end
      end
    end

    assign btn_count[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt;
    assign limit_hit[i] = lim;
    assign led[i]       = led_q;
  end

  assign any_led = |led;

endmodule

// File: tb/tb_multi_button_counter.sv
// tb/tb_multi_button_counter.sv - scoreboard bench for multi_button_counter
module tb_multi_button_counter;

  localparam int D = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // dut_a: defaults
  logic [3:0]  btn_a, cd_a, clr_a;
  logic [63:0] cnt_a;
  logic [3:0]  deb_a, ev_a, lim_a, led_a;
  logic        any_a;
  // dut_r: auto-repeat
  logic [3:0]  btn_r, cd_r, clr_r;
  logic [63:0] cnt_r;
  logic [3:0]  deb_r, ev_r, lim_r, led_r;
  logic        any_r;
  // dut_w / dut_s: 4-bit single channel, wrap and saturate, shared inputs
  logic        btn_ws, cd_ws, clr_ws;
  logic [3:0]  cnt_w, cnt_s;
  logic        deb_w, ev_w, lim_w, led_w, any_w;
  logic        deb_s, ev_s, lim_s, led_s, any_s;

  multi_button_counter dut_a (
    .clk_12m(clk), .rst_n(rst_n), .btn(btn_a), .count_down(cd_a), .clear(clr_a),
    .btn_count(cnt_a), .btn_debounced(deb_a), .count_event(ev_a), .limit_hit(lim_a),
    .led(led_a), .any_led(any_a));

  multi_button_counter #(.HOLD_CYCLES(50), .REPEAT_CYCLES(10)) dut_r (
    .clk_12m(clk), .rst_n(rst_n), .btn(btn_r), .count_down(cd_r), .clear(clr_r),
    .btn_count(cnt_r), .btn_debounced(deb_r), .count_event(ev_r), .limit_hit(lim_r),
    .led(led_r), .any_led(any_r));

  multi_button_counter #(.NUM_BTNS(1), .COUNT_WIDTH(4), .SATURATE(0)) dut_w (
    .clk_12m(clk), .rst_n(rst_n), .btn(btn_ws), .count_down(cd_ws), .clear(clr_ws),
    .btn_count(cnt_w), .btn_debounced(deb_w), .count_event(ev_w), .limit_hit(lim_w),
    .led(led_w), .any_led(any_w));

  multi_button_counter #(.NUM_BTNS(1), .COUNT_WIDTH(4), .SATURATE(1)) dut_s (
    .clk_12m(clk), .rst_n(rst_n), .btn(btn_ws), .count_down(cd_ws), .clear(clr_ws),
    .btn_count(cnt_s), .btn_debounced(deb_s), .count_event(ev_s), .limit_hit(lim_s),
    .led(led_s), .any_led(any_s));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int inst;
    int ch;
    int cyc;
  } exp_t;

  exp_t exp_q[$];

  task automatic push(input int inst, input int ch, input int c);
    exp_t e;
    e.inst = inst;
    e.ch   = ch;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Every count_event pulse on any instance must match the next expected entry.
  logic [3:0] ev_all [4];
  always_comb begin
    ev_all[0] = ev_a;
    ev_all[1] = ev_r;
    ev_all[2] = {3'b000, ev_w};
    ev_all[3] = {3'b000, ev_s};
  end

  always @(negedge clk) begin
    for (int inst = 0; inst < 4; inst++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (ev_all[inst][ch]) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL event_unexpected: inst=%0d ch=%0d at cyc %0d, none expected", inst, ch, cyc);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.inst != inst || e.ch != ch || e.cyc != cyc) begin
              fails++;
              $display("FAIL event_timing: got inst=%0d ch=%0d cyc=%0d, want inst=%0d ch=%0d cyc=%0d",
                       inst, ch, cyc, e.inst, e.ch, e.cyc);
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_neg(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic test_reset();
    tick(3);
    @(negedge clk);
    tests++;
    if ({cnt_a, deb_a, ev_a, lim_a, led_a, any_a} !== 81'd0) begin
      fails++;
      $display("FAIL reset_a: got cnt=%h deb=%b ev=%b lim=%b led=%b any=%b, want all 0",
               cnt_a, deb_a, ev_a, lim_a, led_a, any_a);
    end
    tests++;
    if ({cnt_r, cnt_w, cnt_s, lim_w, lim_s, led_w, led_s} !== 76'd0) begin
      fails++;
      $display("FAIL reset_others: got cnt_r=%h cnt_w=%h cnt_s=%h, want 0", cnt_r, cnt_w, cnt_s);
    end
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic test_clean_press();
    int p;
    int hi;
    logic any_ok;
    tick(1);
    btn_a[0] = 1'b1;
    p = cyc + 3 + D;
    push(0, 0, p);
    at_neg(p);
    tests++;
    if (deb_a !== 4'b0001) begin
      fails++;
      $display("FAIL press_debounced: got %b, want 0001", deb_a);
    end
    hi = 0;
    any_ok = 1'b1;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (led_a[0]) hi++;
      if (any_a !== led_a[0]) any_ok = 1'b0;
    end
    tests++;
    if (hi != 100) begin
      fails++;
      $display("FAIL led_width: got %0d cycles high, want 100", hi);
    end
    tests++;
    if (!any_ok) begin
      fails++;
      $display("FAIL any_led: got mismatch with led[0], want equal");
    end
    tests++;
    if (cnt_a !== 64'h0000_0000_0000_0001) begin
      fails++;
      $display("FAIL press_count: got %h, want 0000000000000001", cnt_a);
    end
    btn_a[0] = 1'b0;
    tick(25);
    tests++;
    if (deb_a !== 4'b0000) begin
      fails++;
      $display("FAIL release_debounced: got %b, want 0000", deb_a);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 12; i++) begin
      btn_a[1] = ~btn_a[1];
      tick(5);
    end
    tick(30);
    tests++;
    if (cnt_a[31:16] !== 16'd0 || deb_a[1] !== 1'b0) begin
      fails++;
      $display("FAIL bounce: got cnt1=%0d deb1=%b, want 0 0", cnt_a[31:16], deb_a[1]);
    end
  endtask

  task automatic test_repeat();
    int p;
    tick(1);
    btn_r[2] = 1'b1;
    p = cyc + 3 + D;
    push(1, 2, p);
    for (int j = 50; j <= 100; j += 10) push(1, 2, p + j);
    at_neg(p + 85);
    tick(1);
    btn_r[2] = 1'b0;
    tick(40);
    tests++;
    if (cnt_r[47:32] !== 16'd7) begin
      fails++;
      $display("FAIL repeat_count: got %0d, want 7", cnt_r[47:32]);
    end
    tests++;
    if (lim_r !== 4'b0000) begin
      fails++;
      $display("FAIL repeat_limit: got %b, want 0000", lim_r);
    end
  endtask

  task automatic test_wrap_saturate();
    int p;
    cd_ws = 1'b1;
    tick(1);
    btn_ws = 1'b1;
    p = cyc + 3 + D;
    push(2, 0, p);
    push(3, 0, p);
    at_neg(p + 2);
    tests++;
    if (cnt_w !== 4'd15 || lim_w !== 1'b1) begin
      fails++;
      $display("FAIL wrap_down: got cnt=%0d lim=%b, want 15 1", cnt_w, lim_w);
    end
    tests++;
    if (cnt_s !== 4'd0 || lim_s !== 1'b1) begin
      fails++;
      $display("FAIL saturate_down: got cnt=%0d lim=%b, want 0 1", cnt_s, lim_s);
    end
    tick(1);
    clr_ws = 1'b1;
    tick(1);
    clr_ws = 1'b0;
    @(negedge clk);
    tests++;
    if (cnt_w !== 4'd0 || lim_w !== 1'b0 || lim_s !== 1'b0) begin
      fails++;
      $display("FAIL clear_ws: got cnt_w=%0d lim_w=%b lim_s=%b, want 0 0 0", cnt_w, lim_w, lim_s);
    end
    btn_ws = 1'b0;
    tick(30);
  endtask

  task automatic test_simultaneous();
    int p;
    cd_a[3] = 1'b1;
    tick(1);
    btn_a[3] = 1'b1;
    p = cyc + 3 + D;
    push(0, 3, p);
    at_neg(p + 2);
    tests++;
    if (cnt_a[63:48] !== 16'hFFFF || lim_a[3] !== 1'b1) begin
      fails++;
      $display("FAIL wrap16: got cnt3=%h lim3=%b, want ffff 1", cnt_a[63:48], lim_a[3]);
    end
    btn_a[3] = 1'b0;
    tick(30);
    btn_a[0] = 1'b1;
    btn_a[3] = 1'b1;
    p = cyc + 3 + D;
    push(0, 0, p);
    push(0, 3, p);
    at_neg(p);
    clr_a[3] = 1'b1;
    tick(1);
    clr_a[3] = 1'b0;
    @(negedge clk);
    tests++;
    if (cnt_a[15:0] !== 16'd2 || cnt_a[63:48] !== 16'd0) begin
      fails++;
      $display("FAIL simul_counts: got ch0=%0d ch3=%0d, want 2 0", cnt_a[15:0], cnt_a[63:48]);
    end
    tests++;
    if (lim_a[3] !== 1'b0 || led_a[0] !== 1'b1 || led_a[3] !== 1'b1) begin
      fails++;
      $display("FAIL simul_flags: got lim3=%b led=%b, want 0 and led0/led3 high", lim_a[3], led_a);
    end
    btn_a[0] = 1'b0;
    btn_a[3] = 1'b0;
    tick(30);
  endtask

  task automatic test_reset_mid_repeat();
    int p;
    int r;
    tick(1);
    btn_r[2] = 1'b1;
    p = cyc + 3 + D;
    push(1, 2, p);
    push(1, 2, p + 50);
    at_neg(p + 55);
    tick(1);
    rst_n = 1'b0;
    r = cyc;
    tick(1);
    rst_n = 1'b1;
    push(1, 2, r + 4 + D);
    @(negedge clk);
    tests++;
    if ({cnt_r, deb_r, ev_r, lim_r, led_r, any_r} !== 81'd0) begin
      fails++;
      $display("FAIL reset_mid_repeat: got cnt=%h deb=%b ev=%b lim=%b led=%b any=%b, want all 0",
               cnt_r, deb_r, ev_r, lim_r, led_r, any_r);
    end
    at_neg(r + 6 + D);
    tests++;
    if (cnt_r[47:32] !== 16'd1) begin
      fails++;
      $display("FAIL repress_count: got %0d, want 1", cnt_r[47:32]);
    end
    tick(1);
    btn_r[2] = 1'b0;
    tick(30);
  endtask

  initial begin
    rst_n  = 1'b0;
    btn_a  = '0; cd_a = '0; clr_a = '0;
    btn_r  = '0; cd_r = '0; clr_r = '0;
    btn_ws = 1'b0; cd_ws = 1'b0; clr_ws = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_wrap_saturate();
    test_simultaneous();
    test_reset_mid_repeat();
    tick(40);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missed_events: got %0d expected events never seen, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_button_counter.md
# multi_button_counter

Parametrised successor to the single-button super counter. It provides N independent button channels, each with its own debouncer, up/down counter, auto-repeat on long press and LED pulse stretcher. Counter width, debounce time, repeat timing and wrap/saturate behaviour are all configurable. It sits between raw board buttons and the UART/display reporting logic, and exposes flattened per-channel counts plus aggregate status.

## Interface
- NUM_BTNS, 4: number of independent channels (1..8)
- COUNT_WIDTH, 16: per-channel counter width (4..32)
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples required to accept a level change (≥2)
- HOLD_CYCLES, 0: cycles a debounced press must be held before auto-repeat starts; 0 disables auto-repeat
- REPEAT_CYCLES, 1200: period between auto-repeat events once repeating (≥1)
- LED_PULSE_CYCLES, 100: LED on-time per event (1..2^16-1)
- SATURATE, 0: 0 = counters wrap modulo 2^COUNT_WIDTH; 1 = counters clamp at 0 and at all-ones

Ports:
- clk_12m  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- btn  in  NUM_BTNS  raw asynchronous buttons, active-high; X/Z is treated as 0
- count_down  in  NUM_BTNS  per-channel direction, sampled when an event occurs: 0 = +1, 1 = −1
- clear  in  NUM_BTNS  synchronous per-channel counter clear
- btn_count  out  NUM_BTNS*COUNT_WIDTH  channel i at [i*COUNT_WIDTH +: COUNT_WIDTH]
- btn_debounced  out  NUM_BTNS  debounced level per channel
- count_event  out  NUM_BTNS  one-cycle pulse on each press or repeat event
- limit_hit  out  NUM_BTNS  sticky; set when an event wraps or is clamped; cleared by clear[i]
- led  out  NUM_BTNS  per-channel stretched pulse
- any_led  out  1  OR of led

## Operation
- Reset (rst_n=0 at a clock edge) clears all state.
  - Every output is 0, including btn_count, btn_debounced, count_event, limit_hit, led and any_led.
  - Synchroniser, debounce, hold, repeat and LED counters return to 0.
- Per channel, the input first passes through a 2-FF synchroniser.
- Debounce:
  - While the synchronised level equals the debounced level, the debounce counter holds at 0.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES−1 it updates the debounced level and returns to 0.
  - Any glitch back to the debounced level restarts the count.
- Event generation:
  - A press event is generated on the rising edge of the debounced level.
  - If HOLD_CYCLES>0 and the debounced level stays high, the first repeat event fires HOLD_CYCLES cycles after the press event.
  - Further repeat events then fire every REPEAT_CYCLES cycles until release.
  - Release of the debounced level cancels pending repeats immediately.
- Channel FSM: IDLE → PRESSED (on debounced rise) → REPEATING (on hold expiry) → IDLE (on debounced fall). PRESSED also returns to IDLE on debounced fall.
- Counter update on an event:
  - count_down=0 gives +1; count_down=1 gives −1.
  - Wrap mode: all-ones+1 → 0 and 0−1 → all-ones, and limit_hit[i] is set.
  - Saturate mode: the count is unchanged at the limit, and limit_hit[i] is set.
- clear[i] has priority over a coincident event: the count goes to 0, limit_hit[i] goes to 0, and the event is discarded for counting. count_event and led still respond to that event.
- LED:
  - Each event reloads the LED counter with LED_PULSE_CYCLES.
  - led[i] is high while that counter is non-zero, so it stays on for exactly LED_PULSE_CYCLES cycles after the last event.
  - A retrigger restarts the full period.
- Channels are fully independent. Simultaneous events on different channels are all counted in the same cycle.

## Timing
- Latency: btn[i] first sampled 1 at edge k, and stable thereafter.
  - btn_debounced[i] rises after edge k+1+DEBOUNCE_CYCLES.
  - count_event[i] is high in the following cycle (after edge k+2+DEBOUNCE_CYCLES).
  - btn_count and led[i] update after edge k+3+DEBOUNCE_CYCLES.
- Release latency is symmetric for btn_debounced.
- Repeat: count_event pulses are exactly HOLD_CYCLES cycles after the press pulse, then every REPEAT_CYCLES cycles.
- clear takes effect at the edge where it is sampled; btn_count reads 0 the next cycle.
- Reset mid-operation (pressed, repeating, or LED active) aborts on the next edge. A button still held after reset must re-debounce and produces a new press event.
- All outputs are registered except any_led, which is a combinational OR of registered led.

## Structure
- Package super_counter_pkg:
  - channel-state enum (IDLE, PRESSED, REPEATING);
  - localparam width helpers via $clog2 for the debounce, hold/repeat and LED counters.
- Sub-module button_channel:
  - one per channel, generated by a for-generate loop;
  - contains the synchroniser, debounce logic, channel FSM, repeat timer and event output.
- The counter, limit and LED logic stay in the top level, indexed per channel.

## Test plan
- Clean press, defaults, ch0:
  - hold btn[0] high for 100 cycles → one count_event after 2+16 cycles;
  - btn_count[15:0]=1 and led[0] high for exactly 100 cycles;
  - other channels stay at 0.
- Bounce: toggle btn[1] every 5 cycles for 60 cycles, then hold low → no event, btn_count ch1=0.
- Auto-repeat, HOLD_CYCLES=50 and REPEAT_CYCLES=10:
  - hold btn[2] for 100 cycles after the press event → events at +0, +50, +60 … +100;
  - btn_count ch2=7; release stops further events.
- Wrap vs saturate, COUNT_WIDTH=4 and count_down=1:
  - one press from 0 → SATURATE=0 gives 15 with limit_hit=1;
  - SATURATE=1 gives 0 with limit_hit=1.
- Simultaneous: press on ch0 and ch3 in the same cycle while clear[3]=1 → ch0=1, ch3=0, both led high, limit_hit[3]=0.
- Reset mid-repeat: assert rst_n=0 for 1 cycle during REPEATING with btn held → all outputs 0; a new press event arrives 2+DEBOUNCE_CYCLES cycles after reset release.
